tc_array: RTL and testbench
===========================

Name: tc_array

Overview:
- Parametrised successor to the single-channel timer/counter. One instance holds N_CH independent down-counting timers behind one word-addressed register window on the bridge.
- Adds three things the single timer lacks: configurable counter width, a per-channel interrupt mask, and a per-channel prescaler.
- Per-channel IRQ lines and an OR-reduced irq_any feed the CPU interrupt inputs.

Parameters:
N_CH, 2, number of timer channels (1..16)
CNT_W, 32, width of PRESET/COUNT (1..32)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
Addr  input  6  word address Addr[7:2] within block; [7:4] channel, [3:2] register
WE  input  1  write enable, one-cycle write at rising edge
Din  input  32  write data
Dout  output  32  combinational read data for Addr
IRQ  output  N_CH  per-channel interrupt, IRQ[i] = pend[i] & IM[i]
irq_any  output  1  OR of IRQ

Behaviour:
- Register map per channel:
  - reg 0 CTRL: [0] Enable, [2:1] Mode, [3] IM, [15:8] PRESC. Other bits read 0.
  - reg 1 PRESET: CNT_W bits.
  - reg 2 COUNT: read-only.
  - reg 3 reserved: reads 0, writes ignored.
- Channel index >= N_CH: reads 0, writes ignored.
- Width rules: PRESET/COUNT are zero-extended on read. Din is truncated to CNT_W on PRESET write. Writes to COUNT are ignored.
- Reset (reset low, asynchronous):
  - All CTRL/PRESET/COUNT/prescale counters/pend = 0; state IDLE.
  - IRQ = 0, irq_any = 0, Dout reflects zeroed registers.
- Per-channel FSM:
  - IDLE: Enable=1 -> LOAD.
  - LOAD: COUNT <= PRESET, pscnt <= 0 -> CNT.
  - CNT:
    - Enable=0 -> IDLE; COUNT holds.
    - Otherwise tick when pscnt == PRESC (pscnt <= 0), else pscnt <= pscnt+1.
    - On tick: COUNT > 1 -> COUNT-1; COUNT <= 1 -> COUNT <= 0, go to INT, pend <= 1.
  - INT, Mode 00 (one-shot): Enable <= 0 -> IDLE. pend stays set until any CTRL write to that channel.
  - INT, Mode 01 (auto-reload): -> LOAD. pend is high only for the single INT cycle.
  - Modes 10/11 behave as 00.
- Latency (PRESC=0, PRESET=P>=1): Enable written at edge e0; IRQ rises after edge e0+P+2. PRESET=0 behaves as P=1.
- With PRESC=k, each decrement takes k+1 CNT cycles.
- Simultaneous CTRL write and INT-state Enable clear: the software write wins for CTRL bits; pend is cleared.
- PRESET written during CNT: takes effect only at the next LOAD.
- CTRL write with Enable=0 during CNT: IDLE next edge, COUNT frozen and readable.
- Re-enable always passes through LOAD, so COUNT restarts from PRESET.
- IM=0 masks IRQ but pend still latches; setting IM later cannot raise IRQ, because the CTRL write clears pend.
- Reset asserted mid-count: immediate return to reset values; no IRQ glitch after release.
- Channels fully independent; several IRQ bits may assert in the same cycle.

Optional Feature:
- Macro: TC_ARRAY_PRESCALE_EN.
- Defined: PRESC field implemented as above.
- Undefined: CTRL[15:8] is not stored and reads 0; tick occurs every CNT cycle; no prescale counter logic.

Test Plan:
1. ch0 PRESET=5, CTRL=0x9 (Enable, mode 00, IM), write at edge e0 -> IRQ[0], irq_any rise after e0+7 and stay high; COUNT=0; Enable reads 0; CTRL write 0x8 drops IRQ[0] next cycle.
2. ch1 PRESET=3, CTRL=0xB (mode 01, IM) -> IRQ[1] one-cycle pulses every 5 cycles (LOAD+3 CNT+INT); ch0 idle with IRQ[0]=0 throughout.
3. Prescale (macro defined): PRESET=2, CTRL=0x0309 -> COUNT holds each value 4 cycles, IRQ after 2+2*4 cycles past enable; macro undefined: CTRL reads 0x0009, IRQ after 4.
4. Mid-count CTRL=0 when COUNT=0x10 -> COUNT frozen at 0x10 or 0xF per edge rule, no IRQ; re-enable reloads PRESET.
5. Addr channel 3 with N_CH=2, Addr reg 3, write to COUNT -> reads 0, no state change; CNT_W=8 PRESET write 0x1FF reads 0xFF.
6. reset low while ch0 in CNT with pend set -> all registers 0 and IRQ 0 asynchronously; after release no IRQ until re-programmed.

Source files
------------

// File: rtl/tc_array_if.sv
// rtl/tc_array_if.sv - word-addressed register bus between the bridge and tc_array
interface tc_array_if;
    logic [5:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;

    modport master (output Addr, output WE, output Din, input Dout);
    modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/tc_array.sv
// rtl/tc_array.sv - N_CH down-counting timers behind one register window.
// Per-channel prescaler is built only when TC_ARRAY_PRESCALE_EN is defined.
module tc_array #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    tc_array_if.slave       bus,
    output logic [N_CH-1:0] IRQ,
    output logic            irq_any
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    state_t           state_q  [N_CH];
    state_t           state_d  [N_CH];
    logic             en_q     [N_CH];
    logic             en_d     [N_CH];
    logic [1:0]       mode_q   [N_CH];
    logic [1:0]       mode_d   [N_CH];
    logic             im_q     [N_CH];
    logic             im_d     [N_CH];
    logic [CNT_W-1:0] preset_q [N_CH];
    logic [CNT_W-1:0] preset_d [N_CH];
    logic [CNT_W-1:0] count_q  [N_CH];
    logic [CNT_W-1:0] count_d  [N_CH];
    logic             pend_q   [N_CH];
    logic             pend_d   [N_CH];
`ifdef TC_ARRAY_PRESCALE_EN
    logic [7:0]       presc_q  [N_CH];
    logic [7:0]       presc_d  [N_CH];
    logic [7:0]       pscnt_q  [N_CH];
    logic [7:0]       pscnt_d  [N_CH];
`endif

    logic [3:0] ch;
    logic [1:0] rsel;
    logic       wr_ctrl   [N_CH];
    logic       wr_preset [N_CH];
    logic       tick      [N_CH];
    logic       unused_din;

    assign ch         = bus.Addr[5:2];
    assign rsel       = bus.Addr[1:0];
    assign unused_din = ^bus.Din;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            wr_ctrl[i]   = bus.WE && (ch == 4'(i)) && (rsel == 2'd0);
            wr_preset[i] = bus.WE && (ch == 4'(i)) && (rsel == 2'd1);
`ifdef TC_ARRAY_PRESCALE_EN
            tick[i]      = (pscnt_q[i] == presc_q[i]);
`else
            tick[i]      = 1'b1;
`endif
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i]  = state_q[i];
            en_d[i]     = en_q[i];
            mode_d[i]   = mode_q[i];
            im_d[i]     = im_q[i];
            preset_d[i] = preset_q[i];
            count_d[i]  = count_q[i];
            pend_d[i]   = pend_q[i];
`ifdef TC_ARRAY_PRESCALE_EN
            presc_d[i]  = presc_q[i];
            pscnt_d[i]  = pscnt_q[i];
`endif
            case (state_q[i])
                S_IDLE: if (en_q[i]) state_d[i] = S_LOAD;
                S_LOAD: begin
                    count_d[i] = preset_q[i];
`ifdef TC_ARRAY_PRESCALE_EN
                    pscnt_d[i] = 8'd0;
`endif
                    state_d[i] = S_CNT;
                end
                S_CNT: begin
                    if (!en_q[i]) begin
                        state_d[i] = S_IDLE;
                    end else if (tick[i]) begin
`ifdef TC_ARRAY_PRESCALE_EN
                        pscnt_d[i] = 8'd0;
`endif
                        // PRESET=0 lands here on the first tick, same as PRESET=1
                        if (count_q[i] > CNT_W'(1)) begin
                            count_d[i] = count_q[i] - CNT_W'(1);
                        end else begin
                            count_d[i] = '0;
                            state_d[i] = S_INT;
                            pend_d[i]  = 1'b1;
                        end
                    end
`ifdef TC_ARRAY_PRESCALE_EN
                    else begin
                        pscnt_d[i] = pscnt_q[i] + 8'd1;
                    end
`endif
                end
                S_INT: begin
                    if (mode_q[i] == 2'b01) begin
                        state_d[i] = S_LOAD;
                        pend_d[i]  = 1'b0;
                    end else begin
                        en_d[i]    = 1'b0;
                        state_d[i] = S_IDLE;
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase

            // Software CTRL write overrides the hardware Enable clear and drops pend
            if (wr_ctrl[i]) begin
                en_d[i]   = bus.Din[0];
                mode_d[i] = bus.Din[2:1];
                im_d[i]   = bus.Din[3];
                pend_d[i] = 1'b0;
`ifdef TC_ARRAY_PRESCALE_EN
                presc_d[i] = bus.Din[15:8];
`endif
            end
            if (wr_preset[i]) preset_d[i] = bus.Din[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= S_IDLE;
                en_q[i]     <= 1'b0;
                mode_q[i]   <= 2'b00;
                im_q[i]     <= 1'b0;
                preset_q[i] <= '0;
                count_q[i]  <= '0;
                pend_q[i]   <= 1'b0;
`ifdef TC_ARRAY_PRESCALE_EN
                presc_q[i]  <= 8'd0;
                pscnt_q[i]  <= 8'd0;
`endif
            end
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
`ifdef TC_ARRAY_PRESCALE_EN
            presc_q  <= presc_d;
            pscnt_q  <= pscnt_d;
`endif
        end
    end

    always_comb begin
        bus.Dout = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch == 4'(i)) begin
                case (rsel)
`ifdef TC_ARRAY_PRESCALE_EN
                    2'd0: bus.Dout = {16'd0, presc_q[i], 4'd0, im_q[i], mode_q[i], en_q[i]};
`else
                    2'd0: bus.Dout = {16'd0, 8'd0, 4'd0, im_q[i], mode_q[i], en_q[i]};
`endif
                    2'd1: bus.Dout = 32'(preset_q[i]);
                    2'd2: bus.Dout = 32'(count_q[i]);
                    default: bus.Dout = '0;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) IRQ[i] = pend_q[i] & im_q[i];
        irq_any = |IRQ;
    end
endmodule

// File: tb/tb_tc_array.sv
// tb/tb_tc_array.sv - scoreboard bench for tc_array (32-bit and 8-bit counter instances)
module tb_tc_array;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] irq;
    logic       irq_any;
    logic [1:0] irq8;
    logic       irq_any8;
    logic       chk_req;

    tc_array_if bus ();
    tc_array_if bus8 ();

    tc_array #(.N_CH(2), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .bus(bus), .IRQ(irq), .irq_any(irq_any)
    );
    tc_array #(.N_CH(2), .CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8), .IRQ(irq8), .irq_any(irq_any8)
    );

    always #5 clk = ~clk;

`ifdef TC_ARRAY_PRESCALE_EN
    localparam bit PRESC_ON = 1'b1;
`else
    localparam bit PRESC_ON = 1'b0;
`endif

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        it;
    logic [31:0] act;
    int          vec_cnt  = 0;
    int          miss_cnt = 0;

    // kind 0: Dout of 32-bit DUT, kind 1: {irq_any, IRQ}, kind 2: Dout of 8-bit DUT
    always @(negedge clk) begin
        if (chk_req) begin
            vec_cnt++;
            if (sb.size() == 0) begin
                miss_cnt++;
                $display("FAIL sb_empty: check requested with no expected value");
            end else begin
                it = sb.pop_front();
                if (it.kind == 0)      act = bus.Dout;
                else if (it.kind == 1) act = {29'd0, irq_any, irq};
                else                   act = bus8.Dout;
                if (act !== it.exp) begin
                    miss_cnt++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        bus.Addr = a; bus.Din = d; bus.WE = 1'b1;
        @(posedge clk);
        #1 bus.WE = 1'b0;
    endtask

    task automatic wr8(input logic [5:0] a, input logic [31:0] d);
        bus8.Addr = a; bus8.Din = d; bus8.WE = 1'b1;
        @(posedge clk);
        #1 bus8.WE = 1'b0;
    endtask

    task automatic chk(input int kind, input logic [5:0] a, input logic [31:0] e, input string nm);
        exp_t x;
        if (kind == 2) bus8.Addr = a;
        else           bus.Addr  = a;
        x.kind = kind; x.exp = e; x.name = nm;
        sb.push_back(x);
        chk_req = 1'b1;
        @(negedge clk);
        #1 chk_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        reset = 1'b0; chk_req = 1'b0;
        bus.WE = 1'b0;  bus.Addr = '0;  bus.Din = '0;
        bus8.WE = 1'b0; bus8.Addr = '0; bus8.Din = '0;
        adv(2);
        #2 reset = 1'b1;
        chk(0, 6'd0, 32'h0, "rst_ctrl0");
        adv(1); chk(0, 6'd2, 32'h0, "rst_count0");
        adv(1); chk(1, 6'd0, 32'h0, "rst_irq");
        adv(1); chk(0, 6'd5, 32'h0, "rst_preset1");

        // one-shot with IM: IRQ after e0+7, held until CTRL write
        wr(6'd1, 32'd5);
        wr(6'd0, 32'h9);
        adv(3); chk(0, 6'd2, 32'd4, "t1_count_e3");
        adv(3); chk(1, 6'd0, 32'h0, "t1_irq_e6");
        adv(1); chk(1, 6'd0, 32'h5, "t1_irq_e7");
        adv(1); chk(0, 6'd2, 32'h0, "t1_count_zero");
        adv(1); chk(0, 6'd0, 32'h8, "t1_enable_cleared");
        adv(3); chk(1, 6'd0, 32'h5, "t1_irq_hold");
        wr(6'd0, 32'h8);
        chk(1, 6'd0, 32'h0, "t1_irq_drop");

        // auto-reload: one-cycle pulse every 5 cycles on IRQ[1] only
        wr(6'd5, 32'd3);
        wr(6'd4, 32'hB);
        for (int k = 1; k <= 15; k++) begin
            adv(1);
            chk(1, 6'd0, (k >= 5 && (k % 5) == 0) ? 32'h6 : 32'h0, $sformatf("t2_irq_c%0d", k));
        end
        wr(6'd4, 32'h0);
        adv(3); chk(1, 6'd0, 32'h0, "t2_stopped");

        // prescaler
        wr(6'd1, 32'd2);
        wr(6'd0, 32'h309);
        chk(0, 6'd0, PRESC_ON ? 32'h309 : 32'h9, "t3_ctrl_read");
        lat = PRESC_ON ? 10 : 4;
        adv(lat - 1); chk(1, 6'd0, 32'h0, "t3_irq_before");
        adv(1);       chk(1, 6'd0, 32'h5, "t3_irq_at");
        wr(6'd0, 32'h0);
        chk(1, 6'd0, 32'h0, "t3_cleared");

        // mid-count disable, then reload on re-enable
        wr(6'd1, 32'h20);
        wr(6'd0, 32'h9);
        adv(18); chk(0, 6'd2, 32'h10, "t4_count_10");
        wr(6'd0, 32'h0);
        adv(3); chk(0, 6'd2, 32'hF, "t4_frozen");
        adv(1); chk(1, 6'd0, 32'h0, "t4_no_irq");
        wr(6'd0, 32'h9);
        adv(2); chk(0, 6'd2, 32'h20, "t4_reload");
        wr(6'd0, 32'h0);
        adv(2); chk(0, 6'd2, 32'h1F, "t4_stop");

        // address decode, read-only COUNT, width truncation
        wr(6'd12, 32'hFFFF_FFFF);
        wr(6'd13, 32'h1234);
        wr(6'd3, 32'hFFFF);
        wr(6'd2, 32'h55);
        chk(0, 6'd12, 32'h0, "t5_ch3_ctrl");
        adv(1); chk(0, 6'd13, 32'h0, "t5_ch3_preset");
        adv(1); chk(0, 6'd3, 32'h0, "t5_reserved");
        adv(1); chk(0, 6'd2, 32'h1F, "t5_count_ro");
        adv(1); chk(0, 6'd1, 32'h20, "t5_preset_keep");
        adv(1); chk(0, 6'd0, 32'h0, "t5_ctrl_keep");
        adv(1); chk(1, 6'd0, 32'h0, "t5_irq");
        wr8(6'd1, 32'h1FF);
        chk(2, 6'd1, 32'hFF, "t5_w8_preset0");
        wr8(6'd5, 32'hABCD);
        chk(2, 6'd5, 32'hCD, "t5_w8_preset1");

        // asynchronous reset mid-count with pend set
        wr(6'd1, 32'h20);
        wr(6'd0, 32'h9);
        wr(6'd5, 32'd1);
        wr(6'd4, 32'h9);
        adv(4); chk(1, 6'd0, 32'h6, "t6_pre_reset_irq");
        adv(1);
        reset = 1'b0;
        chk(1, 6'd0, 32'h0, "t6_async_irq");
        adv(1); chk(0, 6'd2, 32'h0, "t6_rst_count");
        adv(1); chk(0, 6'd4, 32'h0, "t6_rst_ctrl1");
        adv(1); chk(0, 6'd1, 32'h0, "t6_rst_preset");
        reset = 1'b1;
        adv(12); chk(1, 6'd0, 32'h0, "t6_post_irq");
        adv(1);  chk(0, 6'd2, 32'h0, "t6_post_count");

        adv(2);
        if (sb.size() != 0) begin
            vec_cnt++;
            miss_cnt++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
